// File: rtl/line_write_buffer_if.sv
// line_write_buffer_if: cache-side and physical-memory-side bus of the line write buffer.
interface line_write_buffer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  cache_read;
    logic                  cache_write;
    logic [ADDR_WIDTH-1:0] cache_address;
    logic [LINE_WIDTH-1:0] cache_wdata;
    logic [LINE_WIDTH-1:0] cache_rdata;
    logic                  cache_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;
    logic                  buf_valid;

    modport slave (
        input  cache_read, cache_write, cache_address, cache_wdata, pmem_rdata, pmem_resp,
        output cache_rdata, cache_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, buf_valid
    );

    modport master (
        output cache_read, cache_write, cache_address, cache_wdata, pmem_rdata, pmem_resp,
        input  cache_rdata, cache_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, buf_valid
    );
endinterface

// File: rtl/line_write_buffer.sv
// line_write_buffer: single-entry write-back buffer between the cache and physical memory.
// Evictions are parked in one cycle, reads go to memory first, the line drains when the bus idles.
module line_write_buffer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input logic                clk,
    input logic                rst_n,
    line_write_buffer_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RD_MEM = 2'd1;
    localparam logic [1:0] S_WR_MEM = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [LINE_WIDTH-1:0] r_buf_data;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_buf_valid;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic                  w_match;

    assign w_aligned = {bus.cache_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    // buf_addr is stored aligned, so a full compare equals a line-tag compare
    assign w_match   = r_buf_valid && (w_aligned == r_buf_addr);

    assign bus.pmem_read    = r_state == S_RD_MEM;
    assign bus.pmem_write   = r_state == S_WR_MEM;
    assign bus.pmem_address = (r_state == S_RD_MEM) ? w_aligned :
                              (r_state == S_WR_MEM) ? r_buf_addr : '0;
    assign bus.pmem_wdata   = (r_state == S_WR_MEM) ? r_buf_data : '0;
    assign bus.cache_resp   = r_state == S_RESP;
    assign bus.cache_rdata  = r_rdata;
    assign bus.buf_valid    = r_buf_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_buf_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // read checks the buffer before memory so it never sees stale data
                    if (bus.cache_read && w_match) begin
                        r_rdata <= r_buf_data;
                        r_state <= S_RESP;
                    end else if (bus.cache_read) begin
                        r_state <= S_RD_MEM;
                    end else if (bus.cache_write && (!r_buf_valid || w_match)) begin
                        r_buf_addr  <= w_aligned;
                        r_buf_data  <= bus.cache_wdata;
                        r_buf_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (bus.cache_write || r_buf_valid) begin
                        r_state <= S_WR_MEM;
                    end
                end
                S_RD_MEM: begin
                    if (bus.pmem_resp) begin
                        r_rdata <= bus.pmem_rdata;
                        r_state <= S_RESP;
                    end
                end
                S_WR_MEM: begin
                    if (bus.pmem_resp) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/line_write_buffer.md
Name: line_write_buffer

Overview:
- Single-entry write-back buffer between the 2-way cache controller/datapath and physical memory.
- Absorbs a dirty-line eviction in one cycle so the following fill read goes to physical memory first.
- Drains the buffered line to physical memory when the bus is otherwise idle.
- Serves reads that hit the buffered line without a physical memory access.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- OFFSET_BITS, 4, line-offset bits. These are forced to zero on every address this block captures or drives.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cache_read  in  1  line read request; held until cache_resp.
- cache_write  in  1  line write (eviction) request; held until cache_resp.
- cache_address  in  ADDR_WIDTH  request address.
- cache_wdata  in  LINE_WIDTH  line to write.
- cache_rdata  out  LINE_WIDTH  registered read data; valid when cache_resp=1.
- cache_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  physical memory read; held until pmem_resp.
- pmem_write  out  1  physical memory write; held until pmem_resp.
- pmem_address  out  ADDR_WIDTH  line-aligned physical address.
- pmem_wdata  out  LINE_WIDTH  buffered line data.
- pmem_rdata  in  LINE_WIDTH  read data; valid when pmem_resp=1.
- pmem_resp  in  1  physical memory completion pulse.
- buf_valid  out  1  buffer holds an undrained line.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, buf_valid=0, buffer address/data 0, state IDLE. A line held at reset is discarded. pmem_read/pmem_write drop immediately, even mid-transaction.
- Internal registers: buf_addr (line-aligned), buf_data, buf_valid, rdata_q.
- match = buf_valid && (cache_address[ADDR_WIDTH-1:OFFSET_BITS] == buf_addr[ADDR_WIDTH-1:OFFSET_BITS]).
- States: IDLE, RD_MEM, WR_MEM, RESP.
- IDLE evaluates in priority order:
  - 1) cache_read && match: rdata_q<=buf_data, go RESP. No pmem access.
  - 2) cache_read && !match: go RD_MEM. The read bypasses a non-matching buffered line.
  - 3) cache_write && (!buf_valid || match): buf_addr<=aligned cache_address, buf_data<=cache_wdata, buf_valid<=1, go RESP. A write to the same line coalesces in place.
  - 4) cache_write && buf_valid && !match: go WR_MEM. Drains the buffer first; the write is re-evaluated on return to IDLE.
  - 5) No request && buf_valid: go WR_MEM (background drain).
  - 6) Otherwise stay IDLE.
- RD_MEM: pmem_read=1, pmem_address=aligned cache_address. On pmem_resp: rdata_q<=pmem_rdata, go RESP. Otherwise stay.
- WR_MEM: pmem_write=1, pmem_address=buf_addr, pmem_wdata=buf_data. On pmem_resp: buf_valid<=0, go IDLE.
  - A pmem transaction is never aborted. A cache request arriving during WR_MEM waits until the drain completes.
- RESP: cache_resp=1 for exactly one cycle, cache_rdata=rdata_q, then IDLE. The requester deasserts its request at the same edge, so IDLE never re-sees a completed request.
- pmem_read and pmem_write are never asserted together. pmem_address is 0 in IDLE and RESP.
- cache_read && cache_write together is illegal. The block treats it as a read.
- cache_rdata holds its last value outside RESP.
- Latencies:
  - Buffer-hit read: 2 cycles request-to-resp.
  - Write into a free or matching buffer: 2 cycles.
  - Read miss: pmem latency + 2 cycles.
  - Write into a full, non-matching buffer: drain latency + 3 cycles.
- Ordering guarantee: a read never returns stale pmem data for a line held in the buffer (case 1 precedes case 2).

Test Plan:
- Reset mid-drain: assert rst_n=0 while pmem_write=1 -> pmem_write=0, buf_valid=0, cache_resp=0 in the same cycle; after release the next read of 0x1230 goes to pmem.
- Eviction then fill: write 0x1230 with data A, then read 0x4560 with pmem latency 5.
  - cache_resp for the write 2 cycles after request; buf_valid=1.
  - pmem_read with address 0x4560 before any pmem_write.
  - After the read completes: pmem_write address 0x1230, data A; then buf_valid=0.
- Buffer hit: buffer holds 0x1230/A; read 0x123E -> cache_rdata=A with cache_resp 2 cycles later; pmem_read never asserted.
- Coalesce: buffer holds 0x1230/A; write 0x1238 with data B -> no pmem_write before resp; buffer data becomes B; the later drain writes B to 0x1230.
- Full-buffer write: buffer holds 0x1230/A; write 0x7770/C with pmem latency 3.
  - pmem_write to 0x1230 completes first.
  - Then C is captured and cache_resp pulses; buf_valid stays 1 with buf_addr=0x7770.
- Background drain and bus exclusivity: random request mix over 1000 cycles -> pmem_read && pmem_write never both 1; cache_resp never wider than 1 cycle; every read returns the most recently written data for its line.
